// File: rtl/w0rm_mem_pkg.sv
// w0rm_mem_pkg
// Shared definitions for the W0RM core memory: bus_size encodings and the
// big-endian byte-lane helpers used for stores and loads. The helpers assume
// a 32-bit bus word, which gives four byte lanes. Lane 3 is bits [31:24] and
// holds byte offset 0.
package w0rm_mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;
    localparam logic [1:0] SIZE_RSVD = 2'd3;

    // Per-lane write enables. Bit i covers bits [8i+7:8i]. Offset 0 maps to lane 3.
    function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            SIZE_BYTE: be = 4'b1000 >> off;
            SIZE_HALF: be = off[1] ? 4'b0011 : 4'b1100;
            SIZE_WORD: be = 4'b1111;
            default:   be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate the right-aligned store data onto every lane it could target.
    function automatic logic [31:0] store_replicate(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] r;
        case (size)
            SIZE_BYTE: r = {4{data[7:0]}};
            SIZE_HALF: r = {2{data[15:0]}};
            default:   r = data;
        endcase
        return r;
    endfunction

    // Shift the addressed lanes down to bit 0 and zero-extend the result.
    // For a byte, the right-shift in bytes is 3-off, which equals ~off.
    function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] size,
                                                 input logic [1:0] off);
        logic [31:0] shifted;
        logic [31:0] r;
        shifted = word >> {~off, 3'b000};
        case (size)
            SIZE_BYTE: r = {24'h000000, shifted[7:0]};
            SIZE_HALF: r = off[1] ? {16'h0000, word[15:0]} : {16'h0000, word[31:16]};
            SIZE_WORD: r = word;
            default:   r = 32'h00000000;
        endcase
        return r;
    endfunction

    // Alignment check. A halfword needs an even address. A word needs addr[1:0] == 0.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        logic m;
        case (size)
            SIZE_HALF: m = off[0];
            SIZE_WORD: m = (off != 2'b00);
            default:   m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/w0rm_core_ram_dp.sv
// w0rm_core_ram_dp
// True dual-port word RAM. Both ports use a synchronous read-first policy.
// Port A is read-only (fetch).
// Port B reads, and writes with a per-byte write enable (data bus).
// Ports:
//   clk                        clock
//   en_a, addr_a, q_a          port A enable, word address, registered read data
//   en_b, addr_b, we_b, wd_b   port B enable, word address, byte enables, write data
//   q_b                        port B registered read data (old contents on a write)
// Contents are never reset.
module w0rm_core_ram_dp
    import w0rm_mem_pkg::*;
#(
    parameter int DEPTH     = 1024,
    parameter int AW        = 10,
    parameter int DW        = 32,
    parameter     INIT_FILE = ""
) (
    input  logic            clk,
    input  logic            en_a,
    input  logic [AW-1:0]   addr_a,
    output logic [DW-1:0]   q_a,
    input  logic            en_b,
    input  logic [AW-1:0]   addr_b,
    input  logic [DW/8-1:0] we_b,
    input  logic [DW-1:0]   wd_b,
    output logic [DW-1:0]   q_b
);

    logic [DW-1:0] mem_r [DEPTH];

    // Port A read. A same-cycle port B write to the same word is not yet visible.
    always_ff @(posedge clk) begin
        if (en_a) begin
            q_a <= mem_r[addr_a];
        end
    end

    // Port B read-first access with byte-lane writes.
    always_ff @(posedge clk) begin
        if (en_b) begin
            q_b <= mem_r[addr_b];
            for (int i = 0; i < DW / 8; i++) begin
                if (we_b[i]) begin
                    mem_r[addr_b][8*i +: 8] <= wd_b[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/w0rm_core_memory_bytelane.sv
// w0rm_core_memory_bytelane
// On-chip core memory for the W0RM core, mapped at BASE_ADDR.
// It has an instruction-fetch port (halfword reads) and a data-bus port
// (byte/halfword/word loads and stores). Each accepted request gets exactly one
// response on the next cycle. Bad requests get an error response with zero data
// and leave the RAM untouched.
// Ports:
//   clk, rst_n                                    clock, async active-low reset
//   inst_addr, inst_read, inst_valid_in           fetch request
//   inst_data_out, inst_valid_out, inst_error_out fetch response
//   bus_addr, bus_read, bus_write, bus_valid_in   data request
//   bus_size, bus_data_in                         data request size and store data
//   bus_data_out, bus_valid_out, bus_error_out    data response
module w0rm_core_memory_bytelane
    import w0rm_mem_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    INST_WIDTH = 16,
    parameter int                    MEM_BYTES  = 4096,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h20000000,
    parameter                        INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] inst_addr,
    input  logic                  inst_read,
    input  logic                  inst_valid_in,
    output logic [INST_WIDTH-1:0] inst_data_out,
    output logic                  inst_valid_out,
    output logic                  inst_error_out,
    input  logic [ADDR_WIDTH-1:0] bus_addr,
    input  logic                  bus_read,
    input  logic                  bus_write,
    input  logic                  bus_valid_in,
    input  logic [1:0]            bus_size,
    input  logic [DATA_WIDTH-1:0] bus_data_in,
    output logic [DATA_WIDTH-1:0] bus_data_out,
    output logic                  bus_valid_out,
    output logic                  bus_error_out
);

    localparam int IDX_W = $clog2(MEM_BYTES);
    localparam int WAW   = IDX_W - 2;
    localparam int DEPTH = MEM_BYTES / 4;

    logic                  inst_accept_s, inst_err_s;
    logic                  bus_accept_s, bus_err_s, bus_store_s;
    logic [DATA_WIDTH/8-1:0] bus_we_s;
    logic [DATA_WIDTH-1:0] ram_qa_s, ram_qb_s;
    logic [INST_WIDTH-1:0] inst_data_s;
    logic [DATA_WIDTH-1:0] bus_data_s;

    logic                  inst_valid_r, inst_err_r, inst_half_r;
    logic [INST_WIDTH-1:0] inst_hold_r;
    logic                  bus_valid_r, bus_err_r, bus_load_r;
    logic [1:0]            bus_size_r, bus_off_r;
    logic [DATA_WIDTH-1:0] bus_hold_r;

    // Fetch decode. BASE_ADDR is aligned to MEM_BYTES, so a range check
    // only needs to compare the address bits above the RAM index.
    always_comb begin
        inst_accept_s = inst_read & inst_valid_in;
        inst_err_s    = (inst_addr[ADDR_WIDTH-1:IDX_W] != BASE_ADDR[ADDR_WIDTH-1:IDX_W])
                        | inst_addr[0];
    end

    // Data-bus decode. A store writes only when the request raises no error.
    always_comb begin
        bus_accept_s = bus_valid_in & (bus_read | bus_write);
        bus_err_s    = (bus_addr[ADDR_WIDTH-1:IDX_W] != BASE_ADDR[ADDR_WIDTH-1:IDX_W])
                       | misaligned(bus_size, bus_addr[1:0])
                       | (bus_size == SIZE_RSVD)
                       | (bus_read & bus_write);
        bus_store_s  = bus_accept_s & ~bus_err_s & bus_write;
        if (bus_store_s) begin
            bus_we_s = byte_enable(bus_size, bus_addr[1:0]);
        end else begin
            bus_we_s = 4'b0000;
        end
    end

    w0rm_core_ram_dp #(
        .DEPTH     (DEPTH),
        .AW        (WAW),
        .DW        (DATA_WIDTH),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk    (clk),
        .en_a   (inst_accept_s),
        .addr_a (inst_addr[IDX_W-1:2]),
        .q_a    (ram_qa_s),
        .en_b   (bus_accept_s),
        .addr_b (bus_addr[IDX_W-1:2]),
        .we_b   (bus_we_s),
        .wd_b   (store_replicate(bus_size, bus_data_in)),
        .q_b    (ram_qb_s)
    );

    // Fetch response register. An async reset drops any response in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_valid_r <= 1'b0;
            inst_err_r   <= 1'b0;
            inst_half_r  <= 1'b0;
            inst_hold_r  <= 16'h0000;
        end else begin
            inst_valid_r <= inst_accept_s;
            inst_err_r   <= inst_accept_s & inst_err_s;
            if (inst_accept_s) begin
                inst_half_r <= inst_addr[1];
            end
            inst_hold_r <= inst_data_s;
        end
    end

    // Data response register. Size and offset are kept for the lane mux in the response cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_valid_r <= 1'b0;
            bus_err_r   <= 1'b0;
            bus_load_r  <= 1'b0;
            bus_size_r  <= 2'b00;
            bus_off_r   <= 2'b00;
            bus_hold_r  <= 32'h00000000;
        end else begin
            bus_valid_r <= bus_accept_s;
            bus_err_r   <= bus_accept_s & bus_err_s;
            if (bus_accept_s) begin
                bus_load_r <= bus_read & ~bus_write;
                bus_size_r <= bus_size;
                bus_off_r  <= bus_addr[1:0];
            end
            bus_hold_r <= bus_data_s;
        end
    end

    // Output data. These are driven only from registers.
    // Errors and store acknowledges return zero.
    // Between responses the last value is held.
    always_comb begin
        if (!inst_valid_r) begin
            inst_data_s = inst_hold_r;
        end else if (inst_err_r) begin
            inst_data_s = 16'h0000;
        end else if (inst_half_r) begin
            inst_data_s = ram_qa_s[15:0];
        end else begin
            inst_data_s = ram_qa_s[31:16];
        end

        if (!bus_valid_r) begin
            bus_data_s = bus_hold_r;
        end else if (bus_err_r || !bus_load_r) begin
            bus_data_s = 32'h00000000;
        end else begin
            bus_data_s = lane_extract(ram_qb_s, bus_size_r, bus_off_r);
        end
    end

    assign inst_data_out  = inst_data_s;
    assign inst_valid_out = inst_valid_r;
    assign inst_error_out = inst_err_r;
    assign bus_data_out   = bus_data_s;
    assign bus_valid_out  = bus_valid_r;
    assign bus_error_out  = bus_err_r;

endmodule

// File: tb/tb_w0rm_core_memory_bytelane.sv
// tb_w0rm_core_memory_bytelane
// Scoreboard bench. Each issued request queues its expected response, tagged with
// the cycle it must appear in. A negedge monitor pops and compares every response.
module tb_w0rm_core_memory_bytelane;

    localparam logic [31:0] B = 32'h20000000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] inst_addr = 32'h0;
    logic        inst_read = 1'b0, inst_valid_in = 1'b0;
    logic [15:0] inst_data_out;
    logic        inst_valid_out, inst_error_out;
    logic [31:0] bus_addr = 32'h0;
    logic        bus_read = 1'b0, bus_write = 1'b0, bus_valid_in = 1'b0;
    logic [1:0]  bus_size = 2'd0;
    logic [31:0] bus_data_in = 32'h0;
    logic [31:0] bus_data_out;
    logic        bus_valid_out, bus_error_out;

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic        chk_data;
        int          cyc;
    } exp_t;

    exp_t bus_q[$];
    exp_t inst_q[$];
    int   n_vec = 0;
    int   n_fail = 0;
    int   cyc = 0;

    w0rm_core_memory_bytelane dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .inst_addr      (inst_addr),
        .inst_read      (inst_read),
        .inst_valid_in  (inst_valid_in),
        .inst_data_out  (inst_data_out),
        .inst_valid_out (inst_valid_out),
        .inst_error_out (inst_error_out),
        .bus_addr       (bus_addr),
        .bus_read       (bus_read),
        .bus_write      (bus_write),
        .bus_valid_in   (bus_valid_in),
        .bus_size       (bus_size),
        .bus_data_in    (bus_data_in),
        .bus_data_out   (bus_data_out),
        .bus_valid_out  (bus_valid_out),
        .bus_error_out  (bus_error_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: each response must match the head of its queue, in the promised cycle.
    always @(negedge clk) begin
        exp_t e;
        if (bus_valid_out) begin
            if (bus_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL bus_unexpected: response at cycle %0d with none pending", cyc);
            end else begin
                e = bus_q.pop_front();
                check("bus_cycle", cyc, e.cyc);
                check("bus_err", {31'd0, bus_error_out}, {31'd0, e.err});
                if (e.chk_data) check("bus_data", bus_data_out, e.data);
            end
        end
        if (inst_valid_out) begin
            if (inst_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL inst_unexpected: response at cycle %0d with none pending", cyc);
            end else begin
                e = inst_q.pop_front();
                check("inst_cycle", cyc, e.cyc);
                check("inst_err", {31'd0, inst_error_out}, {31'd0, e.err});
                if (e.chk_data) check("inst_data", {16'd0, inst_data_out}, e.data);
            end
        end
    end

    task automatic bus_req(input logic [31:0] a, input logic rd, input logic wr, input logic [1:0] sz,
                           input logic [31:0] d, input logic [31:0] exp_d, input logic exp_e,
                           input logic chk);
        exp_t e;
        bus_addr = a; bus_read = rd; bus_write = wr; bus_size = sz; bus_data_in = d;
        bus_valid_in = 1'b1;
        e.data = exp_d; e.err = exp_e; e.chk_data = chk; e.cyc = cyc + 1;
        bus_q.push_back(e);
    endtask

    task automatic inst_req(input logic [31:0] a, input logic [31:0] exp_d, input logic exp_e,
                            input logic chk);
        exp_t e;
        inst_addr = a; inst_read = 1'b1; inst_valid_in = 1'b1;
        e.data = exp_d; e.err = exp_e; e.chk_data = chk; e.cyc = cyc + 1;
        inst_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        bus_valid_in = 1'b0; bus_read = 1'b0; bus_write = 1'b0;
        inst_valid_in = 1'b0; inst_read = 1'b0;
    endtask

    task automatic st(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        bus_req(a, 1'b0, 1'b1, sz, d, 32'h0, 1'b0, 1'b0);
        step();
    endtask

    task automatic ld(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] exp_d);
        bus_req(a, 1'b1, 1'b0, sz, 32'h0, exp_d, 1'b0, 1'b1);
        step();
    endtask

    task automatic bad(input logic [31:0] a, input logic rd, input logic wr, input logic [1:0] sz);
        bus_req(a, rd, wr, sz, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b1);
        step();
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_inst_data"}, {16'd0, inst_data_out}, 32'h0);
        check({tag, "_inst_valid"}, {31'd0, inst_valid_out}, 32'h0);
        check({tag, "_inst_err"}, {31'd0, inst_error_out}, 32'h0);
        check({tag, "_bus_data"}, bus_data_out, 32'h0);
        check({tag, "_bus_valid"}, {31'd0, bus_valid_out}, 32'h0);
        check({tag, "_bus_err"}, {31'd0, bus_error_out}, 32'h0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst_n = 1'b1;
        step();

        // Word store and load.
        st(B + 32'd16, 2'd2, 32'hDEADBEEF);
        ld(B + 32'd16, 2'd2, 32'hDEADBEEF);

        // Back-to-back fetches of both halfwords (big-endian).
        inst_req(B + 32'd16, 32'hDEAD, 1'b0, 1'b1);
        step();
        inst_req(B + 32'd18, 32'hBEEF, 1'b0, 1'b1);
        step();
        step();
        check("inst_hold", {16'd0, inst_data_out}, 32'hBEEF);

        // Byte store: only the low byte of the data lands, at offset 1.
        st(B + 32'd17, 2'd0, 32'h1234565A);
        ld(B + 32'd16, 2'd2, 32'hDE5ABEEF);
        ld(B + 32'd17, 2'd0, 32'h0000005A);
        ld(B + 32'd18, 2'd1, 32'h0000BEEF);
        ld(B + 32'd16, 2'd0, 32'h000000DE);

        // A same-cycle store and fetch returns the old data.
        // A fetch and a load on the next cycle see the new data.
        bus_req(B + 32'd16, 1'b0, 1'b1, 2'd2, 32'h11223344, 32'h0, 1'b0, 1'b0);
        inst_req(B + 32'd16, 32'hDE5A, 1'b0, 1'b1);
        step();
        inst_req(B + 32'd16, 32'h1122, 1'b0, 1'b1);
        bus_req(B + 32'd16, 1'b1, 1'b0, 2'd2, 32'h0, 32'h11223344, 1'b0, 1'b1);
        step();

        // Halfword and byte lanes in the lower half of a word.
        st(B + 32'd20, 2'd2, 32'h00000000);
        st(B + 32'd22, 2'd1, 32'hFFFFABCD);
        ld(B + 32'd20, 2'd2, 32'h0000ABCD);
        st(B + 32'd23, 2'd0, 32'h00000077);
        ld(B + 32'd20, 2'd2, 32'h0000AB77);
        ld(B + 32'd22, 2'd1, 32'h0000AB77);

        // Error responses, none of which may write.
        bad(B + 32'd2, 1'b1, 1'b0, 2'd2);
        bad(B + 32'd4096, 1'b1, 1'b0, 2'd2);
        bad(B + 32'd16, 1'b0, 1'b1, 2'd3);
        bad(B + 32'd16, 1'b1, 1'b1, 2'd2);
        bad(B + 32'd17, 1'b0, 1'b1, 2'd1);
        bad(B - 32'd4, 1'b0, 1'b1, 2'd2);
        bad(B + 32'd4096, 1'b0, 1'b1, 2'd0);
        ld(B + 32'd16, 2'd2, 32'h11223344);
        step();
        check("bus_hold", bus_data_out, 32'h11223344);
        check("bus_idle_valid", {31'd0, bus_valid_out}, 32'h0);

        inst_req(B + 32'd17, 32'h0, 1'b1, 1'b1);
        step();
        inst_req(B + 32'd4096, 32'h0, 1'b1, 1'b1);
        step();

        // Last word of the array.
        st(B + 32'd4092, 2'd2, 32'hCAFEF00D);
        ld(B + 32'd4092, 2'd2, 32'hCAFEF00D);
        inst_req(B + 32'd4094, 32'hF00D, 1'b0, 1'b1);
        step();
        step();

        // Reset between acceptance and response: the responses must never appear.
        bus_addr = B + 32'd16; bus_read = 1'b1; bus_write = 1'b0; bus_size = 2'd2;
        bus_valid_in = 1'b1;
        inst_addr = B + 32'd16; inst_read = 1'b1; inst_valid_in = 1'b1;
        step();
        rst_n = 1'b0;
        #1;
        check_zero_outputs("midreset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) step();

        // RAM contents survive reset.
        ld(B + 32'd16, 2'd2, 32'h11223344);
        repeat (3) step();

        check("bus_pending", bus_q.size(), 32'd0);
        check("inst_pending", inst_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
